braille_answer_checker: RTL
===========================

# braille_answer_checker

Parametrised answer checker for the Braille trainer. It latches a target symbol from the random generator and accepts up to MAX_TRIES player attempts with a post-miss lockout and an optional response timeout. It emits single-cycle correct/wrong/reveal pulses and keeps saturating score and streak counters for the display path. It sits between the RNG/symbol source, the player input decoder and the seven-segment/feedback drivers.

## Interface

Parameters:
- SYM_W, 4, symbol width in bits
- MAX_TRIES, 3, attempts per round (>=1)
- LOCK_CYC, 2, cycles valid is ignored after a non-final miss (>=1)
- TIMEOUT_CYC, 0, cycles in ARMED without an attempt before a forced miss; 0 disables the timeout
- SCORE_W, 8, width of score and streak

Ports (TW = $clog2(MAX_TRIES+1)):
- clk  in  1  system clock; all state changes on posedge
- rst  in  1  reset, asynchronous, active-high
- target_load  in  1  starts a new round; samples target
- target  in  SYM_W  symbol to be guessed
- valid  in  1  player attempt strobe, one attempt per high cycle
- player_sym  in  SYM_W  player-entered symbol
- correct_pulse  out  1  one cycle, attempt matched
- wrong_pulse  out  1  one cycle, attempt mismatched or timeout
- timeout_pulse  out  1  one cycle, coincident with wrong_pulse when the miss was a timeout
- reveal_pulse  out  1  one cycle, last try used without a match
- segen  out  1  display enable
- busy  out  1  high in ARMED or LOCKOUT
- tries_left  out  TW  remaining attempts this round
- score  out  SCORE_W  total correct rounds, saturating
- streak  out  SCORE_W  consecutive correct rounds, saturating

## Operation

- States: IDLE, ARMED, LOCKOUT, DONE.
- Reset (asynchronous): state=IDLE, all pulses=0, segen=0, tries_left=0, score=0, streak=0, stored target=0, lock and timeout counters=0.
- IDLE/DONE: on target_load, latch target, set tries_left=MAX_TRIES, clear segen, clear the timeout counter, go to ARMED. valid is ignored.
- ARMED, valid=1, player_sym==stored target: correct_pulse, segen<=1, score+1, streak+1, go to DONE. tries_left is not decremented.
- ARMED, valid=1, mismatch: wrong_pulse, segen<=1, tries_left-1.
  - If the new tries_left is 0: reveal_pulse in the same cycle, streak<=0, go to DONE.
  - Otherwise load the lock counter with LOCK_CYC and go to LOCKOUT.
- ARMED, TIMEOUT_CYC>0, no valid for TIMEOUT_CYC consecutive cycles: treated exactly as a mismatch, plus timeout_pulse.
- LOCKOUT: valid is ignored. The counter decrements each cycle; at 0, return to ARMED with the timeout counter cleared.
- target_load in ARMED or LOCKOUT aborts the round: streak<=0, no pulses, re-arm with the new target and tries_left=MAX_TRIES.
- target_load and valid in the same cycle: load wins and the attempt is discarded.
- Timeout expiry and valid in the same cycle: valid wins; it is evaluated as a normal attempt with no timeout_pulse.
- score and streak hold at 2^SCORE_W-1; they never wrap.
- Comparison is full SYM_W-bit equality.

## Timing

- All outputs are registered. Pulses are high for exactly one cycle, in the cycle after the edge that sampled valid (or the expiring timeout).
- Counters update on that same edge, so score/streak/tries_left are visible together with the pulse.
- Attempt-to-next-accept after a non-final miss: LOCK_CYC+1 cycles. A valid exactly LOCK_CYC+1 cycles after the miss edge is accepted.
- Timeout fires on the TIMEOUT_CYC-th consecutive idle ARMED cycle.
- segen rises with the first attempt pulse of a round and falls on the edge that loads the next target.
- busy is combinational from state only.
- Reset asserted mid-round clears everything immediately. The first action after release is target_load.

## Test plan

- Bench parameters MAX_TRIES=3, LOCK_CYC=2, TIMEOUT_CYC=8. Load target=4'h5; valid with player_sym=5 -> correct_pulse 1 cycle, score=1, streak=1, tries_left=3, segen=1, state DONE.
- Load 4'hA; misses 1, 2, 3, each spaced after its lockout -> wrong_pulse x3, tries_left 2, 1, 0, reveal_pulse with the third miss, streak=0.
- Miss, then valid at +1 and +2 cycles (ignored, no pulse), then valid=match at +3 -> single correct_pulse, tries_left=2.
- Load, no attempt for 8 cycles -> wrong_pulse+timeout_pulse, tries_left=2. Load again with valid matching on the 8th idle cycle -> correct_pulse only.
- target_load and valid together in ARMED -> no pulse, new target latched, tries_left=3. Streak preload 0xFF at SCORE_W=8 with further correct rounds -> score and streak stay 0xFF.
- Assert rst asynchronously during LOCKOUT -> all outputs 0 before the next edge; valid afterwards gives no pulse until target_load.

Source files
------------

// File: rtl/braille_answer_checker.sv
// Answer checker for the Braille trainer: latches a target symbol, scores player
// attempts with post-miss lockout and optional timeout, and tracks score/streak.
module braille_answer_checker #(
  parameter int SYM_W       = 4,
  parameter int MAX_TRIES   = 3,
  parameter int LOCK_CYC    = 2,
  parameter int TIMEOUT_CYC = 0,
  parameter int SCORE_W     = 8,
  localparam int TW         = $clog2(MAX_TRIES + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               target_load,
  input  logic [SYM_W-1:0]   target,
  input  logic               valid,
  input  logic [SYM_W-1:0]   player_sym,
  output logic               correct_pulse,
  output logic               wrong_pulse,
  output logic               timeout_pulse,
  output logic               reveal_pulse,
  output logic               segen,
  output logic               busy,
  output logic [TW-1:0]      tries_left,
  output logic [SCORE_W-1:0] score,
  output logic [SCORE_W-1:0] streak
);

  localparam int LW  = $clog2(LOCK_CYC + 1);
  localparam int TOW = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam bit TIMEOUT_EN = (TIMEOUT_CYC > 0);
  localparam logic [TOW-1:0] TO_LAST = TIMEOUT_EN ? TOW'(TIMEOUT_CYC - 1) : '0;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ARMED   = 2'd1;
  localparam logic [1:0] S_LOCKOUT = 2'd2;
  localparam logic [1:0] S_DONE    = 2'd3;

  logic [1:0]       state;
  logic [SYM_W-1:0] target_q;
  logic [LW-1:0]    lock_cnt;
  logic [TOW-1:0]   to_cnt;

  logic attempt, hit, timeout_fire, miss, last_try;

  // A load in the same cycle always wins, so attempts and timeouts are masked by it.
  assign attempt      = (state == S_ARMED) && valid && !target_load;
  assign hit          = attempt && (player_sym == target_q);
  assign timeout_fire = TIMEOUT_EN && (state == S_ARMED) && !valid && !target_load
                        && (to_cnt == TO_LAST);
  assign miss         = (attempt && !hit) || timeout_fire;
  assign last_try     = (tries_left == TW'(1));

  assign busy = (state == S_ARMED) || (state == S_LOCKOUT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_IDLE;
      target_q      <= '0;
      lock_cnt      <= '0;
      to_cnt        <= '0;
      correct_pulse <= 1'b0;
      wrong_pulse   <= 1'b0;
      timeout_pulse <= 1'b0;
      reveal_pulse  <= 1'b0;
      segen         <= 1'b0;
      tries_left    <= '0;
      score         <= '0;
      streak        <= '0;
    end else begin
      correct_pulse <= hit;
      wrong_pulse   <= miss;
      timeout_pulse <= timeout_fire;
      reveal_pulse  <= miss && last_try;
      if (target_load) begin
        if (busy) streak <= '0;
        target_q   <= target;
        tries_left <= TW'(MAX_TRIES);
        segen      <= 1'b0;
        to_cnt     <= '0;
        state      <= S_ARMED;
      end else begin
        case (state)
          S_ARMED: begin
            if (hit) begin
              segen <= 1'b1;
              if (score != '1)  score  <= score + SCORE_W'(1);
              if (streak != '1) streak <= streak + SCORE_W'(1);
              state <= S_DONE;
            end else if (miss) begin
              segen      <= 1'b1;
              tries_left <= tries_left - TW'(1);
              if (last_try) begin
                streak <= '0;
                state  <= S_DONE;
              end else begin
                lock_cnt <= LW'(LOCK_CYC);
                state    <= S_LOCKOUT;
              end
            end else if (TIMEOUT_EN) begin
              to_cnt <= to_cnt + TOW'(1);
            end
          end
          S_LOCKOUT: begin
            // Leave on the edge that empties the counter so the next cycle accepts valid.
            if (lock_cnt == LW'(1)) begin
              lock_cnt <= '0;
              to_cnt   <= '0;
              state    <= S_ARMED;
            end else begin
              lock_cnt <= lock_cnt - LW'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
